ones_count_detector: RTL
========================

Name: ones_count_detector

Overview:
- Parametrised detector that counts '1' samples on a serial input bit and signals every Nth counted '1'.
- Has two detection modes:
  - cumulative: zeros are ignored.
  - consecutive: a zero breaks the run.
- Provides a combinational Mealy hit output and a registered flag output, plus a saturating hit counter.
- Sits in the serial-input front end as a generalised event/sequence detector feeding downstream control logic.

Parameters:
- N, 4, number of '1' samples per hit; legal range N >= 2.
- HIT_W, 8, width of the saturating hit counter.
- CNT_W, $clog2(N), localparam, width of the position counter; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  sample enable; data is sampled only when en=1.
- clr  input  1  synchronous clear of count, flag and hits.
- mode  input  1  0 = cumulative, 1 = consecutive.
- data  input  1  serial input bit.
- hit  output  1  combinational (Mealy) hit indication for the current cycle.
- flag  output  1  registered hit, one cycle after hit.
- count  output  CNT_W  current position counter, range 0..N-1.
- hits  output  HIT_W  number of hits since reset/clr, saturating.
- hits_sat  output  1  high while hits is saturated (all ones).

Behaviour:
- Reset (rst=1, asynchronous): count=0, flag=0, hits=0, hits_sat=0. hit is forced to 0 while rst=1.
- hit = !rst & !clr & en & data & (count==N-1). It is purely combinational and has no latency.
- Per rising clk edge, priority is top-down:
  1. clr=1: count<=0, flag<=0, hits<=0. en and data are ignored.
  2. en=0: count and hits hold; flag<=0.
  3. en=1, data=1, count==N-1: count<=0 (wrap), flag<=1, hits<=hits+1 unless already all ones.
  4. en=1, data=1, count<N-1: count<=count+1, flag<=0.
  5. en=1, data=0, mode=0: count holds, flag<=0.
  6. en=1, data=0, mode=1: count<=0, flag<=0.
- flag is therefore a one-cycle pulse equal to the previous cycle's hit.
  - Back-to-back hits are impossible for N>=2.
  - The minimum hit spacing is N enabled '1' samples.
- Counting is non-overlapping: after a hit the next hit needs N further '1' samples.
- mode is sampled each cycle with no internal copy.
  - A change takes effect in the same cycle without clearing count.
  - Example: count=2 and mode switches 0->1 while data=0 gives count<=0.
- hits saturates at 2^HIT_W-1 and never wraps. hits_sat = (hits == all ones). Only rst or clr clears it.
- count never exceeds N-1. For non-power-of-two N, count values >= N are unreachable.
- An rst assertion mid-run clears all state immediately, regardless of clk.
- The first edge after rst deassertion behaves as from count=0.

Decomposition:
- Shared package ocd_pkg:
  - localparam MODE_CUMULATIVE = 1'b0 and MODE_CONSECUTIVE = 1'b1.
  - Helper function for CNT_W.
- One sub-module, sat_counter:
  - Parameter W.
  - Ports clk, rst, clr, inc; outputs value[W-1:0] and sat.
  - Saturating increment.
  - Instantiated for hits with inc = hit.
- The position counter and next-state logic stay in the top module.

Test Plan:
- N=4, mode=0, en=1, data=1,0,1,0,1,1 -> count 1,1,2,2,3,0; hit=1 on the 6th sample; flag=1 the following cycle only; hits=1.
- N=4, mode=1, en=1, data=1,1,1,0,1,1,1,1 -> count resets to 0 on the zero; single hit on the 8th sample; hits=1.
- N=4, en toggled: data=1 with en=1,0,1,1,1 -> count holds during en=0; hit on the 5th cycle; flag=0 on the en=0 cycle.
- N=4, count=3, data=1, en=1, clr=1 in the same cycle -> hit=0; next state count=0, flag=0, hits=0 (clr wins).
- N=2, HIT_W=2, continuous data=1 for 10 cycles -> hits 1,2,3 then stays 3; hits_sat=1 from the 3rd hit onward; flag keeps pulsing every 2nd cycle.
- rst asserted asynchronously between edges at count=2, hits=1 -> count, flag and hits go to 0 immediately; hit=0 while rst=1.

Source files
------------

// File: rtl/ones_count_detector_pkg.sv
// Shared definitions for the ones-count detector: detection mode encodings and counter sizing.
// Pure declarations; no logic, latency or flow control of its own.
package ocd_pkg;

  localparam logic MODE_CUMULATIVE  = 1'b0;
  localparam logic MODE_CONSECUTIVE = 1'b1;

  // A one-bit position counter is still required when N == 2, where $clog2 already gives 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ones_count_detector_sat_counter.sv
// Saturating up-counter; value updates on the edge after inc and sticks at all ones.
// No backpressure: inc is taken every cycle it is high, clr overrides inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         sat
);

  assign sat = &value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !sat) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/ones_count_detector.sv
// Counts enabled '1' samples and raises hit on every Nth; hit is same-cycle, flag/hits follow one edge later.
// No backpressure: one sample per enabled cycle, clr takes priority over sampling.
module ones_count_detector
  import ocd_pkg::*;
#(
  parameter int N     = 4,
  parameter int HIT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    mode,
  input  logic                    data,
  output logic                    hit,
  output logic                    flag,
  output logic [cnt_width(N)-1:0] count,
  output logic [HIT_W-1:0]        hits,
  output logic                    hits_sat
);

  localparam int               CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  logic at_last;

  assign at_last = (count == LAST);
  assign hit     = !rst && !clr && en && data && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (!en) begin
      flag  <= 1'b0;
    end else if (data) begin
      // Wrap instead of overlapping: the next hit needs a fresh group of N ones.
      if (at_last) begin
        count <= '0;
        flag  <= 1'b1;
      end else begin
        count <= count + 1'b1;
        flag  <= 1'b0;
      end
    end else begin
      flag <= 1'b0;
      if (mode == MODE_CONSECUTIVE) begin
        count <= '0;
      end
    end
  end

  sat_counter #(
    .W(HIT_W)
  ) u_hits (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (hit),
    .value(hits),
    .sat  (hits_sat)
  );

endmodule
